// File: rtl/dodgeball_pkg.sv
// dodgeball_pkg: screen geometry, palette and game-state encoding shared by the dodgeball blocks
package dodgeball_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam logic [7:0] COLOR_BALL   = 8'hFF;
    localparam logic [7:0] COLOR_PLAYER = 8'h1C;
    localparam logic [7:0] COLOR_FLASH  = 8'hE0;
    localparam logic [7:0] COLOR_OVER   = 8'h20;
    typedef enum logic [1:0] {PLAY, HIT_FLASH, OVER} state_t;
endpackage

// File: rtl/ball_motion.sv
// ball_motion: one-axis next position and direction with wall clamping
module ball_motion #(
    parameter int LIMIT = 640,
    parameter int SIZE  = 8,
    parameter int SPEED = 2
) (
    input  logic [11:0] pos,
    input  logic        dir,
    output logic [11:0] pos_n,
    output logic        dir_n
);
    logic [12:0] fwd;
    logic        bounce_hi;
    logic        bounce_lo;
    always_comb begin
        fwd       = {1'b0, pos} + 13'(SPEED) + 13'(SIZE);
        bounce_hi = dir && fwd >= 13'(LIMIT);
        bounce_lo = !dir && pos <= 12'(SPEED);
        pos_n     = bounce_hi ? 12'(LIMIT - SIZE) : bounce_lo ? 12'd0 :
                    dir ? pos + 12'(SPEED) : pos - 12'(SPEED);
        dir_n     = bounce_hi ? 1'b0 : bounce_lo ? 1'b1 : dir;
    end
endmodule

// File: rtl/ball_pixel_gen.sv
// ball_pixel_gen: per-frame ball motion, player collision, dodge scoring and pixel colour
module ball_pixel_gen
    import dodgeball_pkg::*;
#(
    parameter int BALL_SIZE        = 8,
    parameter int BALL_SPEED       = 2,
    parameter int BALL_X0          = 320,
    parameter int BALL_Y0          = 40,
    parameter int PLAYER_Y         = 440,
    parameter int PLAYER_W         = 32,
    parameter int PLAYER_H         = 8,
    parameter int LIVES            = 3,
    parameter int FLASH_FRAMES     = 30,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [11:0] player_x,
    output logic [7:0]  rgb,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        hit,
    output logic        game_over
);
    state_t      state_q, state_d;
    logic [11:0] bx_q, bx_d, by_q, by_d, mx, my;
    logic        dx_q, dx_d, dy_q, dy_d, mdx, mdy;
    logic [7:0]  score_q, score_d, flash_q, flash_d, rgb_q, rgb_d;
    logic [1:0]  lives_q, lives_d;
    logic        hit_q, hit_d, va_q, va_d, tick_q, tick_d;
    logic        coll, floor_hit, in_ball, in_player;

    ball_motion #(.LIMIT(H_ACTIVE), .SIZE(BALL_SIZE), .SPEED(BALL_SPEED)) u_mx (
        .pos(bx_q), .dir(dx_q), .pos_n(mx), .dir_n(mdx)
    );
    ball_motion #(.LIMIT(V_ACTIVE), .SIZE(BALL_SIZE), .SPEED(BALL_SPEED)) u_my (
        .pos(by_q), .dir(dy_q), .pos_n(my), .dir_n(mdy)
    );

    always_comb begin
        va_d      = VSYNC_ACTIVE_LOW ? !vsync : vsync;
        tick_d    = va_d && !va_q;
        coll      = {1'b0, mx} < {1'b0, player_x} + 13'(PLAYER_W) &&
                    {1'b0, player_x} < {1'b0, mx} + 13'(BALL_SIZE) &&
                    {1'b0, my} < 13'(PLAYER_Y + PLAYER_H) &&
                    13'(PLAYER_Y) < {1'b0, my} + 13'(BALL_SIZE);
        floor_hit = {1'b0, my} + 13'(BALL_SIZE) >= 13'(V_ACTIVE);
        state_d   = state_q;
        bx_d      = bx_q;
        by_d      = by_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        score_d   = score_q;
        lives_d   = lives_q;
        flash_d   = flash_q;
        hit_d     = 1'b0;
        if (tick_q && state_q == PLAY) begin
            bx_d = mx;
            by_d = my;
            dx_d = mdx;
            dy_d = mdy;
            if (coll) begin
                hit_d   = 1'b1;
                lives_d = lives_q - 2'd1;
                flash_d = 8'd0;
                state_d = lives_q == 2'd1 ? OVER : HIT_FLASH;
            end else if (floor_hit) begin
                score_d = score_q == 8'hFF ? score_q : score_q + 8'd1;
                bx_d    = 12'(BALL_X0);
                by_d    = 12'(BALL_Y0);
                dx_d    = 1'b1;
                dy_d    = 1'b1;
            end
        end else if (tick_q && state_q == HIT_FLASH) begin
            flash_d = flash_q + 8'd1;
            if (flash_d == 8'(FLASH_FRAMES)) begin
                state_d = PLAY;
                bx_d    = 12'(BALL_X0);
                by_d    = 12'(BALL_Y0);
                dx_d    = 1'b1;
                dy_d    = 1'b1;
            end
        end
        in_ball   = x >= bx_q && {1'b0, x} < {1'b0, bx_q} + 13'(BALL_SIZE) &&
                    y >= by_q && {1'b0, y} < {1'b0, by_q} + 13'(BALL_SIZE);
        in_player = x >= player_x && {1'b0, x} < {1'b0, player_x} + 13'(PLAYER_W) &&
                    y >= 12'(PLAYER_Y) && y < 12'(PLAYER_Y + PLAYER_H);
        rgb_d     = (x >= 12'(H_ACTIVE) || y >= 12'(V_ACTIVE)) ? 8'h00 :
                    in_ball ? COLOR_BALL : in_player ? COLOR_PLAYER :
                    state_q == HIT_FLASH ? COLOR_FLASH : state_q == OVER ? COLOR_OVER : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PLAY;
            bx_q    <= 12'(BALL_X0);
            by_q    <= 12'(BALL_Y0);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            score_q <= 8'd0;
            lives_q <= 2'(LIVES);
            flash_q <= 8'd0;
            hit_q   <= 1'b0;
            rgb_q   <= 8'd0;
            va_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            score_q <= score_d;
            lives_q <= lives_d;
            flash_q <= flash_d;
            hit_q   <= hit_d;
            rgb_q   <= rgb_d;
            va_q    <= va_d;
            tick_q  <= tick_d;
        end
    end

    assign rgb       = rgb_q;
    assign ball_x    = bx_q;
    assign ball_y    = by_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign hit       = hit_q;
    assign game_over = state_q == OVER;
endmodule

// File: tb/tb_ball_pixel_gen.sv
// tb_ball_pixel_gen: directed game scenarios plus randomized play checked against a frame-level game model
module tb_ball_pixel_gen;
    logic        clk = 1'b0;
    logic        rst, vsync;
    logic [11:0] x, y, player_x;
    logic [7:0]  rgb;
    logic [11:0] ball_x, ball_y;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        hit, game_over;
    int checks = 0;
    int failures = 0;
    int mbx, mby, mdx, mdy, mscore, mlives, mst, mflash, mhit;

    always #5 clk = ~clk;

    ball_pixel_gen dut (
        .clk(clk), .rst(rst), .vsync(vsync), .x(x), .y(y), .player_x(player_x),
        .rgb(rgb), .ball_x(ball_x), .ball_y(ball_y), .score(score), .lives(lives),
        .hit(hit), .game_over(game_over)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mbx = 320; mby = 40; mdx = 1; mdy = 1;
        mscore = 0; mlives = 3; mst = 0; mflash = 0; mhit = 0;
    endtask

    task automatic move(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + 2 + 8 >= lim) begin p = lim - 8; d = -1; end
            else p = p + 2;
        end else begin
            if (p <= 2) begin p = 0; d = 1; end
            else p = p - 2;
        end
    endtask

    task automatic model_tick();
        int px;
        px = int'(player_x);
        mhit = 0;
        if (mst == 0) begin
            move(mbx, mdx, 640);
            move(mby, mdy, 480);
            if (mbx < px + 32 && px < mbx + 8 && mby < 448 && 440 < mby + 8) begin
                mhit = 1;
                mlives--;
                mflash = 0;
                mst = (mlives == 0) ? 2 : 1;
            end else if (mby + 8 >= 480) begin
                mscore = (mscore < 255) ? mscore + 1 : 255;
                mbx = 320; mby = 40; mdx = 1; mdy = 1;
            end
        end else if (mst == 1) begin
            mflash++;
            if (mflash == 30) begin
                mst = 0; mbx = 320; mby = 40; mdx = 1; mdy = 1;
            end
        end
    endtask

    function automatic int exp_rgb(input int px, input int py);
        if (px >= 640 || py >= 480) return 0;
        if (px >= mbx && px < mbx + 8 && py >= mby && py < mby + 8) return 'hFF;
        if (px >= int'(player_x) && px < int'(player_x) + 32 && py >= 440 && py < 448) return 'h1C;
        return (mst == 1) ? 'hE0 : (mst == 2) ? 'h20 : 0;
    endfunction

    task automatic probe(input int px, input int py, input int exp);
        x = 12'(px);
        y = 12'(py);
        step();
        check("rgb", rgb, exp);
    endtask

    task automatic rand_probe();
        int r, px, py;
        r = int'($urandom_range(0, 2));
        if (r == 0) begin
            px = mbx + int'($urandom_range(0, 9)) - 1;
            py = mby + int'($urandom_range(0, 9)) - 1;
        end else if (r == 1) begin
            px = int'(player_x) + int'($urandom_range(0, 33)) - 1;
            py = 439 + int'($urandom_range(0, 9));
        end else begin
            px = int'($urandom_range(0, 800));
            py = int'($urandom_range(0, 600));
        end
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        probe(px, py, exp_rgb(px, py));
    endtask

    task automatic frame();
        int hits;
        hits = 0;
        vsync = 1'b1;
        step();
        step();
        vsync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            hits += int'(hit);
        end
        model_tick();
        check("hit_cycles", hits, mhit);
        check("ball_x", ball_x, mbx);
        check("ball_y", ball_y, mby);
        check("score", score, mscore);
        check("lives", lives, mlives);
        check("game_over", game_over, int'(mst == 2));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vsync = 1'b0;
        x = 12'd0;
        y = 12'd0;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int n, px;
        rst = 1'b1; vsync = 1'b0; x = 12'd0; y = 12'd0; player_x = 12'd0;
        do_reset();
        repeat (5) step();
        check("rst_rgb", rgb, 0);
        check("rst_ball_x", ball_x, 320);
        check("rst_ball_y", ball_y, 40);
        check("rst_lives", lives, 3);
        check("rst_score", score, 0);
        check("rst_game_over", game_over, 0);
        check("rst_hit", hit, 0);
        probe(320, 40, 'hFF);
        probe(700, 10, 'h00);
        probe(1, 442, 'h1C);

        for (int f = 1; f <= 216; f++) begin
            frame();
            if (f == 156) check("wall_x156", ball_x, 632);
            if (f == 157) begin
                check("wall_x157", ball_x, 630);
                check("wall_y157", ball_y, 354);
            end
            if (f == 216) begin
                check("dodge_score", score, 1);
                check("dodge_x", ball_x, 320);
                check("dodge_y", ball_y, 40);
            end
            rand_probe();
        end

        player_x = 12'd540;
        do_reset();
        n = 0;
        while (mst != 2 && n < 1000) begin
            frame();
            n++;
            if (n == 197) begin
                check("hit_x", ball_x, 550);
                check("hit_y", ball_y, 434);
                check("hit_lives", lives, 2);
                probe(0, 0, 'hE0);
            end
            if (n == 227) begin
                check("flash_end_x", ball_x, 320);
                check("flash_end_y", ball_y, 40);
                probe(0, 0, 'h00);
            end
            rand_probe();
        end
        check("over_lives", lives, 0);
        check("over_flag", game_over, 1);
        probe(0, 0, 'h20);
        repeat (10) frame();
        check("frozen_x", ball_x, 550);
        check("frozen_y", ball_y, 434);

        rst = 1'b1;
        vsync = 1'b0;
        step();
        check("midover_ball_x", ball_x, 320);
        check("midover_ball_y", ball_y, 40);
        check("midover_lives", lives, 3);
        check("midover_score", score, 0);
        check("midover_game_over", game_over, 0);
        check("midover_rgb", rgb, 0);
        rst = 1'b0;
        model_reset();

        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                px = mbx + int'($urandom_range(0, 80)) - 40;
                player_x = 12'((px < 0) ? 0 : px);
            end else begin
                player_x = 12'($urandom_range(0, 700));
            end
            frame();
            rand_probe();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ball_pixel_gen.md
Name: ball_pixel_gen

Overview:
- Game-logic and pixel-colour stage that sits directly downstream of vga_sync inside dodgeball.
- Consumes the scan position (x, y) and vsync. Advances the ball once per frame, detects player collisions and floor dodges, and produces the 8-bit RRRGGGBB pixel colour for the current scan position.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BALL_SIZE, 8, ball square side (px)
BALL_SPEED, 2, px per frame per axis
BALL_X0, 320, respawn x
BALL_Y0, 40, respawn y
PLAYER_Y, 440, player top row
PLAYER_W, 32, player width
PLAYER_H, 8, player height
LIVES, 3, starting lives (1..3)
FLASH_FRAMES, 30, hit-flash duration in frames
VSYNC_ACTIVE_LOW, 1, vsync polarity

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
vsync  in  1  vertical sync from vga_sync
x  in  12  current scan column
y  in  12  current scan row
player_x  in  12  player left edge, unsigned
rgb  out  8  pixel colour RRRGGGBB
ball_x  out  12  ball left edge
ball_y  out  12  ball top edge
score  out  8  dodge count, saturating
lives  out  2  remaining lives
hit  out  1  one-cycle pulse on collision
game_over  out  1  latched end of game

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.

Reset values:
- rgb=0, ball_x=BALL_X0, ball_y=BALL_Y0, score=0, lives=LIVES, hit=0, game_over=0.
- Direction = +x, +y. State=PLAY. Flash counter=0.
- The vsync history register resets to the ACTIVE level, so no tick fires until a fresh inactive→active edge.
- Reset mid-frame or mid-flash restores all of the above on the next edge.

Frame tick:
- One-cycle internal pulse on the clock after vsync transitions inactive→active.
- All game state changes only on tick. rgb is the exception.

Motion (PLAY, on tick), per axis independently:
- Moving +: if pos+BALL_SPEED+BALL_SIZE >= limit, then pos=limit-BALL_SIZE and direction flips to −. Otherwise pos+=BALL_SPEED.
- Moving −: if pos <= BALL_SPEED, then pos=0 and direction flips to +. Otherwise pos-=BALL_SPEED.
- x limit = H_ACTIVE. y top uses the same rule.
- Both axes may bounce on the same tick (corner).
- All arithmetic is 12-bit unsigned, using 13-bit intermediate sums so there is no wrap.

Collision (evaluated on the updated position, same tick):
- Overlap when ball_x < player_x+PLAYER_W, player_x < ball_x+BALL_SIZE, ball_y < PLAYER_Y+PLAYER_H, and PLAYER_Y < ball_y+BALL_SIZE.
- Collision has priority over floor and bounce results.
- Effects: hit=1 for exactly one cycle, lives−=1.
- If lives becomes 0 → OVER. Else → HIT_FLASH, flash counter=0, ball frozen.

Floor (no collision): updated ball_y+BALL_SIZE >= V_ACTIVE counts as a dodge:
- score+=1, saturating at 255.
- Ball respawns at (BALL_X0, BALL_Y0) with direction +,+.

States:
- PLAY: as above.
- HIT_FLASH: counter+=1 per tick. At FLASH_FRAMES ticks → PLAY, ball respawned at start with direction +,+.
- OVER: game_over=1, ball frozen, score and lives held. Exits only via rst.

Render (registered, latency 1 clk: rgb at cycle n+1 reflects x, y at cycle n), first match wins:
1. x>=H_ACTIVE or y>=V_ACTIVE → 8'h00.
2. Inside ball square → 8'hFF.
3. Inside player rectangle → 8'h1C.
4. Background by state: PLAY 8'h00, HIT_FLASH 8'hE0, OVER 8'h20.

Render uses ball_x/ball_y as held at that cycle.

Decomposition:
- dodgeball_pkg: screen constants (H_ACTIVE, V_ACTIVE), colour constants (COLOR_BALL, COLOR_PLAYER, COLOR_FLASH, COLOR_OVER), state enum {PLAY, HIT_FLASH, OVER}.
- Sub-module ball_motion: per-tick position/direction update and bounce clamping for one axis, instantiated twice.
- Collision, FSM and render stay in ball_pixel_gen.

Test Plan:
- Reset, then release with vsync held active → no tick. rgb=0, ball=(320,40), lives=3, score=0, game_over=0.
- Render: x=320,y=40 → rgb=8'hFF one clk later. x=700,y=10 → 8'h00. x=player_x+1,y=442 → 8'h1C. Each checked at exactly +1 cycle.
- Right-wall bounce, player_x=0: after 156 ticks ball_x=632 and direction flips. Tick 157 → ball_x=630, ball_y=354.
- Floor dodge, player_x=0: on tick 216, score=1 and the ball respawns at (320,40) with direction +,+.
- Hit, player_x=540: tick 197 puts the ball at (550,434).
  - Response: hit pulse exactly 1 cycle, lives=2, background 8'hE0.
  - After 30 further ticks → PLAY, ball=(320,40).
- Game over: repeat the hit three times → lives=0, game_over=1, background 8'h20, ball frozen across 10 ticks. Assert rst mid-OVER → full reset values next cycle.
